// File: rtl/lisp_defs_pkg.sv
// Shared Lisp heap definitions: tags, memory op codes, arbiter states and heap sizing.
// Used by the heap arbiter and kept consistent with the memory block.
package lisp_defs;

  localparam int DEFAULT_MEM_SIZE   = 256;
  localparam int DEFAULT_HEAP_START = 5;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int HEAP_W = 13;

  localparam logic [3:0]        TAG_CONS = 4'h1;
  localparam logic [DATA_W-1:0] LISP_NIL = 16'h0000;

  typedef enum logic {
    MEM_READ = 1'b0,
    MEM_CONS = 1'b1
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_CDR,
    WR_CAR,
    WR_ADDR,
    RESP
  } arb_state_e;

  typedef struct packed {
    mem_op_e           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] car;
    logic [DATA_W-1:0] cdr;
  } client_req_t;

  // One extra bit of width means the +2 never wraps, so a full heap is always caught.
  function automatic logic heap_has_room(input logic [HEAP_W-1:0] heap_next, input int mem_size);
    return (heap_next + HEAP_W'(2)) <= HEAP_W'(mem_size);
  endfunction

  function automatic logic [DATA_W-1:0] cons_ptr(input logic [ADDR_W-1:0] car_addr);
    return {TAG_CONS, car_addr};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both requesting, the client that did not win last time wins.
// The last-grant pointer resets to 1 so client 0 wins the first contended grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_enable,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = o_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_last <= 1'b1;
    end else if (|o_gnt) begin
      o_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port Lisp heap memory between the evaluator (client 0) and reader/printer (client 1).
// Serves READs and CONS allocations with round-robin arbitration and a shadow heap-bound check.
module mem_arbiter
  import lisp_defs::*;
#(
  parameter int MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int HEAP_START = DEFAULT_HEAP_START
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_op,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_car,
  input  logic [DATA_W-1:0] c0_cdr,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic              c1_op,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_car,
  input  logic [DATA_W-1:0] c1_cdr,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_ready,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [ADDR_W-1:0] mem_write_result_addr
);

  arb_state_e        r_state, w_next_state;
  client_req_t       r_req;
  logic              r_client;
  logic [HEAP_W-1:0] r_heap_next;

  client_req_t       w_c0, w_c1, w_sel, w_cur;
  logic [1:0]        w_elig, w_gnt;
  logic              w_grant, w_gnt_id, w_cur_id, w_last, w_fits;

  logic              w_mem_req, w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_c0_ack, w_c1_ack, w_c0_err, w_c1_err;
  logic [DATA_W-1:0] w_c0_rdata, w_c1_rdata;
  logic [DATA_W-1:0] w_resp_data;
  logic              w_resp_err;

  assign w_c0 = '{op: mem_op_e'(c0_op), addr: c0_addr, car: c0_car, cdr: c0_cdr};
  assign w_c1 = '{op: mem_op_e'(c1_op), addr: c1_addr, car: c1_car, cdr: c1_cdr};

  // A client in its own ack cycle is not eligible, so one request never yields two acks.
  assign w_elig = {c1_req & ~c1_ack, c0_req & ~c0_ack};

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_elig),
    .i_enable (r_state == IDLE),
    .o_gnt    (w_gnt),
    .o_last   (w_last)
  );

  assign w_grant  = |w_gnt;
  assign w_gnt_id = w_gnt[1];
  assign w_sel    = w_gnt_id ? w_c1 : w_c0;
  assign w_fits   = heap_has_room(r_heap_next, MEM_SIZE);

  // Outputs are registered from next-state, so the grant cycle must see the live request fields.
  assign w_cur    = (r_state == IDLE) ? w_sel : r_req;
  assign w_cur_id = (r_state == IDLE) ? w_gnt_id : r_client;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_sel.op == MEM_READ) w_next_state = RD_ISSUE;
          else if (w_fits)          w_next_state = WR_CDR;
          else                      w_next_state = RESP;
        end
      end
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT:  w_next_state = mem_data_ready ? RESP : RD_WAIT;
      WR_CDR:   w_next_state = WR_CAR;
      WR_CAR:   w_next_state = WR_ADDR;
      WR_ADDR:  w_next_state = RESP;
      RESP:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= '0;
      r_client    <= 1'b0;
      r_heap_next <= HEAP_W'(HEAP_START);
    end else begin
      if (r_state == IDLE && w_grant) begin
        r_req    <= w_sel;
        r_client <= w_gnt_id;
      end
      if (r_state == IDLE && w_next_state == WR_CDR) begin
        r_heap_next <= r_heap_next + HEAP_W'(2);
      end
    end
  end

  // Response source depends on which state leads into RESP; from IDLE it can only be heap-full.
  always_comb begin
    case (r_state)
      RD_WAIT: begin
        w_resp_data = mem_data_out;
        w_resp_err  = 1'b0;
      end
      WR_ADDR: begin
        w_resp_data = cons_ptr(mem_write_result_addr);
        w_resp_err  = 1'b0;
      end
      default: begin
        w_resp_data = LISP_NIL;
        w_resp_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    w_c0_ack    = 1'b0;
    w_c1_ack    = 1'b0;
    w_c0_rdata  = c0_rdata;
    w_c1_rdata  = c1_rdata;
    w_c0_err    = c0_err;
    w_c1_err    = c1_err;
    case (w_next_state)
      RD_ISSUE: begin
        w_mem_req  = 1'b1;
        w_mem_addr = w_cur.addr;
      end
      WR_CDR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = w_cur.cdr;
      end
      WR_CAR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = w_cur.car;
      end
      RESP: begin
        if (w_cur_id) begin
          w_c1_ack   = 1'b1;
          w_c1_rdata = w_resp_data;
          w_c1_err   = w_resp_err;
        end else begin
          w_c0_ack   = 1'b1;
          w_c0_rdata = w_resp_data;
          w_c0_err   = w_resp_err;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req          <= 1'b0;
      mem_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      c0_ack           <= 1'b0;
      c0_rdata         <= '0;
      c0_err           <= 1'b0;
      c1_ack           <= 1'b0;
      c1_rdata         <= '0;
      c1_err           <= 1'b0;
    end else begin
      mem_req          <= w_mem_req;
      mem_addr         <= w_mem_addr;
      mem_write_enable <= w_mem_we;
      mem_write_data   <= w_mem_wdata;
      c0_ack           <= w_c0_ack;
      c0_rdata         <= w_c0_rdata;
      c0_err           <= w_c0_err;
      c1_ack           <= w_c1_ack;
      c1_rdata         <= w_c1_rdata;
      c1_err           <= w_c1_err;
    end
  end

  logic w_unused;
  assign w_unused = w_last;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port Lisp heap memory between two requesters: client 0 is the evaluator and client 1 is the reader/printer.
- Each client issues either a READ of one 16-bit word or a CONS allocation.
- A CONS writes the CDR word, then the CAR word, then returns a tagged cons pointer {TAG_CONS, car_addr}.
- The block owns all memory handshakes, round-robin arbitration and a shadow heap-bound check.

Parameters:
- MEM_SIZE, 256, number of memory words; must match the memory block.
- HEAP_START, 5, first heap address; must match the memory block.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- c0_req  in  1  client 0 request; held with stable fields until c0_ack
- c0_op  in  1  0 = READ, 1 = CONS (mem_op_e)
- c0_addr  in  12  READ address
- c0_car  in  16  CONS CAR word
- c0_cdr  in  16  CONS CDR word
- c0_ack  out  1  one-cycle completion pulse
- c0_rdata  out  16  read word or cons pointer; valid only with c0_ack
- c0_err  out  1  heap-full flag; valid only with c0_ack
- c1_req, c1_op, c1_addr, c1_car, c1_cdr, c1_ack, c1_rdata, c1_err  same as client 0
- mem_req  out  1  memory read request
- mem_addr  out  12  memory read address
- mem_data_ready  in  1  read data valid; one cycle after mem_req
- mem_data_out  in  16  read data
- mem_write_enable  out  1  memory heap-append write
- mem_write_data  out  16  word to append
- mem_write_result_addr  in  12  address of the last write; valid the cycle after the write

Behaviour:
- Reset: all outputs are registered and reset to 0; state = IDLE; rr_last = 1 so client 0 wins first; heap_next = HEAP_START.
- Reset mid-operation aborts immediately to IDLE. Any memory write already issued is not undone.
- rst is asserted only together with memory reinitialisation, because the memory heap pointer has no reset.
- Grant:
  - Only in IDLE, and only for clients whose req=1 and ack=0. A client's own ack cycle never re-grants it.
  - Both eligible: grant the client != rr_last. rr_last updates on every grant.
  - Grant cycle latches op, addr, car, cdr and the client id.
- READ, with c0 = grant cycle:
  - c1, state RD_ISSUE: mem_req=1, mem_addr=addr.
  - c2, state RD_WAIT: hold until mem_data_ready=1, then capture mem_data_out. mem_req is low in RD_WAIT.
  - c3, state RESP: cX_ack=1, rdata = captured word, err=0.
- CONS:
  - If heap_next + 2 > MEM_SIZE at grant: go to RESP with ack at c1, err=1, rdata=LISP_NIL, no write issued.
  - Otherwise:
    - c1, state WR_CDR: mem_write_enable=1, data=cdr.
    - c2, state WR_CAR: mem_write_enable=1, data=car.
    - c3, state WR_ADDR: capture mem_write_result_addr (the CAR address).
    - c4, state RESP: ack=1, rdata = {TAG_CONS, car_addr}, err=0.
  - heap_next += 2 on entry to WR_CDR.
- RESP always returns to IDLE next cycle. Exactly one ack pulse per grant; the non-granted client's ack stays 0.
- mem_write_enable and mem_req are never high in the same cycle. Idle memory outputs are 0.
- Heap accounting: heap_next is a 13-bit compare so there is no wrap. The last legal cons uses addresses MEM_SIZE-2 and MEM_SIZE-1.
- rdata and err are held at the last value outside ack; their contents are don't-care there.

Decomposition:
- lisp_defs package:
  - TAG_CONS = 4'h1
  - LISP_NIL
  - mem_op_e {MEM_READ, MEM_CONS}
  - arb_state_e {IDLE, RD_ISSUE, RD_WAIT, WR_CDR, WR_CAR, WR_ADDR, RESP}
  - MEM_SIZE and HEAP_START defaults, shared with the memory block
- One sub-module, rr_arb2: 2-way round-robin grant. Inputs: req[1:0], enable. Outputs: one-hot gnt, registered last-grant pointer.

Test Plan:
- Read: c0 READ addr 0x001 -> c0_ack at cycle 3, c0_rdata=16'hBEEF, c0_err=0; c1_ack stays 0.
- Cons: c1 CONS car=16'h1234, cdr=16'h5678 on fresh heap -> two writes at 5 then 6, c1_ack at cycle 4, c1_rdata=16'h1006. A follow-up READ of 0x006 returns 16'h1234, and of 0x005 returns 16'h5678.
- Contention: c0 and c1 both request READ at the same cycle from reset -> c0 is served first (ack cycle 3), then c1 is granted at cycle 4 and acks at cycle 7. Repeat with both held high -> grants alternate.
- Heap full (MEM_SIZE=8, HEAP_START=5): first CONS -> ok (0x1006). Second CONS -> ack at cycle 1, err=1, rdata=LISP_NIL, mem_write_enable never high.
- No re-grant: c0 keeps req high one cycle past ack with a new READ -> that is a new grant after the ack cycle, with exactly one ack per transaction.
- Reset mid-cons: assert rst during WR_CAR -> all outputs are 0 the same cycle (asynchronous), state=IDLE; after release the next request completes normally.
